// File: rtl/rect_draw_engine_if.sv
// Command and framebuffer-port bundle between a drawing client and rect_draw_engine.
// The master modport is the client/framebuffer side; the slave modport is the engine.
interface rect_draw_engine_if #(
  parameter int AW = 17,
  parameter int CW = 3
) ();
  logic          i_cmd_valid;
  logic          o_cmd_ready;
  logic          i_cmd_op;
  logic [8:0]    i_x0;
  logic [8:0]    i_y0;
  logic [8:0]    i_w;
  logic [8:0]    i_h;
  logic [CW-1:0] i_color;
  logic [1:0]    i_mode;
  logic [AW-1:0] o_raddr;
  logic [CW-1:0] i_rdata;
  logic [AW-1:0] o_waddr;
  logic [CW-1:0] o_wdata;
  logic          o_we;
  logic          o_flush;
  logic          o_busy;
  logic          o_done;

  modport master (
    output i_cmd_valid, i_cmd_op, i_x0, i_y0, i_w, i_h, i_color, i_mode, i_rdata,
    input  o_cmd_ready, o_raddr, o_waddr, o_wdata, o_we, o_flush, o_busy, o_done
  );

  modport slave (
    input  i_cmd_valid, i_cmd_op, i_x0, i_y0, i_w, i_h, i_color, i_mode, i_rdata,
    output o_cmd_ready, o_raddr, o_waddr, o_wdata, o_we, o_flush, o_busy, o_done
  );
endinterface

// File: rtl/rect_draw_engine.sv
// Rectangle-fill / flush producer for a double-buffered framebuffer.
// Emits a raster-ordered pixel-write stream, using read-modify-write for AND/OR/XOR modes.
module rect_draw_engine #(
  parameter int H_RES = 400,
  parameter int V_RES = 300,
  parameter int AW    = 17,
  parameter int CW    = 3
) (
  input logic               i_clk,
  input logic               i_reset,
  rect_draw_engine_if.slave bus
);

  typedef enum logic [2:0] {IDLE, RD, WR, FLSH, DONE} state_t;
  typedef enum logic [1:0] {M_REPLACE, M_AND, M_OR, M_XOR} mode_t;

  localparam logic [9:0]    H10  = 10'(H_RES);
  localparam logic [9:0]    V10  = 10'(V_RES);
  localparam logic [AW-1:0] H_AW = AW'(H_RES);

  state_t        state, state_n;
  mode_t         mode_q, mode_n;
  logic [CW-1:0] color_q, color_n;
  logic [9:0]    x0_q, x0_n;
  logic [9:0]    xe_q, xe_n;
  logic [9:0]    ye_q, ye_n;
  logic [9:0]    px_q, px_n;
  logic [9:0]    py_q, py_n;
  logic [AW-1:0] base_q, base_n;
  logic [AW-1:0] addr_n;

  logic [AW-1:0] waddr_q, raddr_q;
  logic [CW-1:0] wdata_q;
  logic          we_q, flush_q, done_q;

  logic [9:0]    sum_x, sum_y;
  logic          empty;
  state_t        pix_state;
  logic [CW-1:0] rmw_data;

  always_comb begin
    sum_x = {1'b0, bus.i_x0} + {1'b0, bus.i_w};
    sum_y = {1'b0, bus.i_y0} + {1'b0, bus.i_h};
    empty = (bus.i_w == '0) || (bus.i_h == '0) ||
            ({1'b0, bus.i_x0} >= H10) || ({1'b0, bus.i_y0} >= V10);
    pix_state = (mode_q == M_REPLACE) ? WR : RD;
  end

  always_comb begin
    state_n = state;
    mode_n  = mode_q;
    color_n = color_q;
    x0_n    = x0_q;
    xe_n    = xe_q;
    ye_n    = ye_q;
    px_n    = px_q;
    py_n    = py_q;
    base_n  = base_q;
    unique case (state)
      IDLE: begin
        if (bus.i_cmd_valid) begin
          if (bus.i_cmd_op) begin
            state_n = FLSH;
          end else if (empty) begin
            state_n = DONE;
          end else begin
            mode_n  = mode_t'(bus.i_mode);
            color_n = bus.i_color;
            x0_n    = {1'b0, bus.i_x0};
            xe_n    = (sum_x > H10) ? H10 : sum_x;
            ye_n    = (sum_y > V10) ? V10 : sum_y;
            px_n    = {1'b0, bus.i_x0};
            py_n    = {1'b0, bus.i_y0};
            // Constant-coefficient product for the starting row only; later rows step by H_RES.
            base_n  = AW'(bus.i_y0) * H_AW;
            state_n = (mode_t'(bus.i_mode) == M_REPLACE) ? WR : RD;
          end
        end
      end
      RD: state_n = WR;
      WR: begin
        if (px_q + 10'd1 < xe_q) begin
          px_n    = px_q + 10'd1;
          state_n = pix_state;
        end else if (py_q + 10'd1 < ye_q) begin
          px_n    = x0_q;
          py_n    = py_q + 10'd1;
          base_n  = base_q + H_AW;
          state_n = pix_state;
        end else begin
          state_n = DONE;
        end
      end
      FLSH:    state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    addr_n = base_n + AW'(px_n);
  end

  // Strobes and addresses are registered from the next state so they line up with the state itself.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state   <= IDLE;
      mode_q  <= M_REPLACE;
      color_q <= '0;
      x0_q    <= '0;
      xe_q    <= '0;
      ye_q    <= '0;
      px_q    <= '0;
      py_q    <= '0;
      base_q  <= '0;
      waddr_q <= '0;
      raddr_q <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      flush_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_n;
      mode_q  <= mode_n;
      color_q <= color_n;
      x0_q    <= x0_n;
      xe_q    <= xe_n;
      ye_q    <= ye_n;
      px_q    <= px_n;
      py_q    <= py_n;
      base_q  <= base_n;
      we_q    <= (state_n == WR);
      flush_q <= (state_n == FLSH);
      done_q  <= (state_n == DONE);
      if (state_n == WR) begin
        waddr_q <= addr_n;
        wdata_q <= color_n;
      end
      if (state_n == RD) begin
        raddr_q <= addr_n;
      end
    end
  end

  // Read data arrives during WR, so the RMW result cannot be registered ahead of time.
  always_comb begin
    unique case (mode_q)
      M_AND:   rmw_data = bus.i_rdata & color_q;
      M_OR:    rmw_data = bus.i_rdata | color_q;
      M_XOR:   rmw_data = bus.i_rdata ^ color_q;
      default: rmw_data = color_q;
    endcase
  end

  assign bus.o_cmd_ready = (state == IDLE);
  assign bus.o_busy      = (state != IDLE);
  assign bus.o_we        = we_q;
  assign bus.o_flush     = flush_q;
  assign bus.o_done      = done_q;
  assign bus.o_waddr     = waddr_q;
  assign bus.o_raddr     = raddr_q;
  assign bus.o_wdata     = (state == WR && mode_q != M_REPLACE) ? rmw_data : wdata_q;

endmodule

// File: tb/tb_rect_draw_engine.sv
// Scoreboard bench for rect_draw_engine: a reference model queues expected write/flush/done
// events at command issue, and an independent monitor pops and compares them.
module tb_rect_draw_engine;

  localparam int KW = 0;
  localparam int KF = 1;
  localparam int KD = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rect_draw_engine_if #(.AW(17), .CW(3)) bus ();

  rect_draw_engine #(.H_RES(400), .V_RES(300), .AW(17), .CW(3)) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (bus)
  );

  typedef struct {
    int kind;
    int addr;
    int data;
  } ev_t;

  ev_t exp_q[$];
  int  ncmp = 0;
  int  nfail = 0;
  int  wr_seen = 0;
  int  done_seen = 0;
  int  flush_seen = 0;
  int  key = 0;

  function automatic int bb(input int a);
    return (a & 7) ^ key;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Back-buffer memory model: data for the presented read address.
  initial begin
    forever begin
      @(negedge clk);
      bus.i_rdata = 3'(bb(int'(bus.o_raddr)));
    end
  end

  // Monitor: every strobe must match the next expected event.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        int k;
        k = int'(bus.o_we) + int'(bus.o_flush) + int'(bus.o_done);
        if (k != 0) begin
          ev_t e;
          int  kind;
          chk("strobe_exclusive", k, 1);
          kind = bus.o_we ? KW : (bus.o_flush ? KF : KD);
          if (kind == KW) wr_seen++;
          if (kind == KF) flush_seen++;
          if (kind == KD) done_seen++;
          if (exp_q.size() == 0) begin
            chk("unexpected_event", kind, -1);
          end else begin
            e = exp_q.pop_front();
            chk("event_kind", kind, e.kind);
            if (kind == KW && e.kind == KW) begin
              chk("waddr", int'(bus.o_waddr), e.addr);
              chk("wdata", int'(bus.o_wdata), e.data);
              chk("waddr_in_range", int'(bus.o_waddr < 17'd120000), 1);
            end
          end
        end
      end
    end
  end

  // Reference model: clipped raster fill; returns the cycles from acceptance to o_done.
  function automatic int model(input int op, input int x0, input int y0, input int w,
                               input int h, input int col, input int mode);
    int xe, ye, n, a, d;
    ev_t e;
    if (op == 1) begin
      e.kind = KF; e.addr = 0; e.data = 0; exp_q.push_back(e);
      e.kind = KD; exp_q.push_back(e);
      return 2;
    end
    xe = (x0 + w > 400) ? 400 : x0 + w;
    ye = (y0 + h > 300) ? 300 : y0 + h;
    n = 0;
    for (int y = y0; y < ye; y++) begin
      for (int x = x0; x < xe; x++) begin
        a = y * 400 + x;
        case (mode)
          1:       d = bb(a) & col;
          2:       d = bb(a) | col;
          3:       d = bb(a) ^ col;
          default: d = col;
        endcase
        e.kind = KW; e.addr = a; e.data = d; exp_q.push_back(e);
        n++;
      end
    end
    e.kind = KD; e.addr = 0; e.data = 0; exp_q.push_back(e);
    return (mode == 0) ? n + 1 : 2 * n + 1;
  endfunction

  int exp_lat;

  // Called at a negedge; returns at the negedge of the first cycle after acceptance.
  task automatic issue(input int op, input int x0, input int y0, input int w, input int h,
                       input int col, input int mode);
    int n;
    bus.i_cmd_op    = 1'(op);
    bus.i_x0        = 9'(x0);
    bus.i_y0        = 9'(y0);
    bus.i_w         = 9'(w);
    bus.i_h         = 9'(h);
    bus.i_color     = 3'(col);
    bus.i_mode      = 2'(mode);
    bus.i_cmd_valid = 1'b1;
    n = 0;
    while (!bus.o_cmd_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("accept_within_bound", int'(bus.o_cmd_ready), 1);
    exp_lat = model(op, x0, y0, w, h, col, mode);
    @(posedge clk);
    @(negedge clk);
    bus.i_cmd_valid = 1'b0;
    bus.i_cmd_op    = 1'($urandom);
    bus.i_x0        = 9'($urandom);
    bus.i_y0        = 9'($urandom);
    bus.i_w         = 9'($urandom);
    bus.i_h         = 9'($urandom);
    bus.i_color     = 3'($urandom);
    bus.i_mode      = 2'($urandom);
  endtask

  task automatic wait_done(input string nm);
    int lat;
    lat = 1;
    while (!bus.o_done && lat < 3000) begin
      @(negedge clk);
      lat++;
    end
    chk(nm, lat, exp_lat);
  endtask

  task automatic run_cmd(input string nm, input int op, input int x0, input int y0,
                         input int w, input int h, input int col, input int mode);
    issue(op, x0, y0, w, h, col, mode);
    wait_done(nm);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int d0, f0, w0, n;
    bus.i_cmd_valid = 1'b0;
    bus.i_cmd_op    = 1'b0;
    bus.i_x0        = '0;
    bus.i_y0        = '0;
    bus.i_w         = '0;
    bus.i_h         = '0;
    bus.i_color     = '0;
    bus.i_mode      = '0;
    repeat (3) @(negedge clk);
    chk("reset_ready", int'(bus.o_cmd_ready), 1);
    chk("reset_we", int'(bus.o_we), 0);
    chk("reset_flush", int'(bus.o_flush), 0);
    chk("reset_busy", int'(bus.o_busy), 0);
    chk("reset_done", int'(bus.o_done), 0);
    chk("reset_waddr", int'(bus.o_waddr), 0);
    chk("reset_raddr", int'(bus.o_raddr), 0);
    chk("reset_wdata", int'(bus.o_wdata), 0);
    rst = 1'b0;
    @(negedge clk);

    run_cmd("lat_replace_3x2", 0, 2, 1, 3, 2, 5, 0);
    key = 6;
    run_cmd("lat_xor_1x1", 0, 0, 0, 1, 1, 3, 3);
    run_cmd("lat_clip_corner", 0, 398, 299, 5, 4, 2, 0);
    run_cmd("lat_empty_w0", 0, 10, 10, 0, 5, 1, 0);
    run_cmd("lat_empty_x400", 0, 400, 10, 5, 5, 1, 2);
    chk("ready_after_empty", int'(bus.o_cmd_ready), 1);

    // FLUSH followed immediately by a FILL held valid while the engine is busy.
    d0 = done_seen;
    f0 = flush_seen;
    issue(1, 0, 0, 0, 0, 0, 0);
    chk("busy_in_flush", int'(bus.o_busy), 1);
    issue(0, 7, 3, 2, 2, 4, 2);
    chk("fill_accepted_after_done", done_seen - d0, 1);
    chk("single_flush", flush_seen - f0, 1);
    wait_done("lat_fill_after_flush");
    @(negedge clk);

    // Reset during row 2 of a 10x10 fill.
    w0 = wr_seen;
    issue(0, 5, 5, 10, 10, 1, 0);
    n = 0;
    while (wr_seen < w0 + 13 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("reached_row2", int'(wr_seen >= w0 + 13), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_we", int'(bus.o_we), 0);
    chk("abort_ready", int'(bus.o_cmd_ready), 1);
    chk("abort_busy", int'(bus.o_busy), 0);
    chk("abort_flush", int'(bus.o_flush), 0);
    chk("abort_done", int'(bus.o_done), 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("ready_after_abort", int'(bus.o_cmd_ready), 1);

    for (int i = 0; i < 24; i++) begin
      int x0, y0;
      key = int'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) begin
        run_cmd("lat_rand_flush", 1, 0, 0, 0, 0, 0, 0);
      end else begin
        x0 = ($urandom_range(0, 1) == 1) ? int'($urandom_range(385, 420)) : int'($urandom_range(0, 399));
        y0 = ($urandom_range(0, 1) == 1) ? int'($urandom_range(288, 310)) : int'($urandom_range(0, 299));
        run_cmd("lat_rand_fill", 0, x0, y0, int'($urandom_range(0, 12)),
                int'($urandom_range(0, 12)), int'($urandom_range(0, 7)),
                int'($urandom_range(0, 3)));
      end
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", ncmp, nfail);
    $finish;
  end

endmodule
